riscv_cache_writebuffer: RTL and testbench

Write buffer that receives store data from the cache address-setup stage and drains it into the cache data memory.
- Writes drain only in cycles where the data memory port is free.
- Bytes still held in the buffer are forwarded to loads that hit the same set/way.
- Sits between the setup/hit stages and the data memory write port; a small circular FIFO with write coalescing.

---
 rtl/riscv_cache_writebuffer_pkg.sv | 34 +++
 rtl/riscv_cache_wb_fwd.sv | 47 ++++
 rtl/riscv_cache_writebuffer.sv | 168 ++++++++++++++++
 tb/tb_riscv_cache_writebuffer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_cache_writebuffer_pkg.sv
// Purpose: shared cache helpers and the write-buffer entry type for the default configuration.
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a.
package riscv_cache_writebuffer_pkg;

    // Number of sets for a cache of cache_size KBytes, block_size bits per block, ways ways
    function automatic integer no_of_sets(input integer cache_size,
                                          input integer block_size,
                                          input integer ways);
        no_of_sets = cache_size * 1024 * 8 / block_size / ways;
    endfunction

    // Width of the set index for the same geometry
    function automatic integer no_of_index_bits(input integer cache_size,
                                                input integer block_size,
                                                input integer ways);
        no_of_index_bits = $clog2(no_of_sets(cache_size, block_size, ways));
    endfunction

    // Default geometry: 64 KByte, 32-bit blocks, 2 ways
    localparam int WB_XLEN     = 32;
    localparam int WB_WAYS     = 2;
    localparam int WB_IDX_BITS = no_of_index_bits(64, WB_XLEN, WB_WAYS);

    // One buffered store: a full XLEN word plus the bytes it actually writes
    typedef struct packed {
        logic                   valid;
        logic [WB_IDX_BITS-1:0] idx;
        logic [WB_WAYS-1:0]     way;
        logic [WB_XLEN-1:0]     data;
        logic [WB_XLEN/8-1:0]   be;
    } wb_entry_t;

endpackage

// File: rtl/riscv_cache_wb_fwd.sv
// Purpose: per-byte store-to-load forwarding over the write-buffer entries, youngest match wins.
// Latency: purely combinational, reads registered entries only.
// Backpressure: none; never stalls, a miss just returns fwd_be=0.
module riscv_cache_wb_fwd
    import riscv_cache_writebuffer_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IDX_BITS = 13,
    parameter int WAYS     = 2,
    parameter int DEPTH    = 2,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int BE_W    = XLEN / 8
) (
    input  logic [PTR_W-1:0]    head,
    input  logic [DEPTH-1:0]    ent_valid,
    input  logic [IDX_BITS-1:0] ent_idx  [DEPTH],
    input  logic [WAYS-1:0]     ent_way  [DEPTH],
    input  logic [XLEN-1:0]     ent_data [DEPTH],
    input  logic [BE_W-1:0]     ent_be   [DEPTH],
    input  logic [IDX_BITS-1:0] lookup_idx,
    input  logic [WAYS-1:0]     lookup_way,
    output logic [BE_W-1:0]     fwd_be,
    output logic [XLEN-1:0]     fwd_data
);

    logic [PTR_W-1:0] slot;

    // Walk entries oldest to youngest so later (younger) matches overwrite earlier bytes
    always_comb begin
        fwd_be   = '0;
        fwd_data = '0;
        slot     = head;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head + PTR_W'(k);
            if (ent_valid[slot] && (ent_idx[slot] == lookup_idx) &&
                ((ent_way[slot] & lookup_way) != '0)) begin
                fwd_be = fwd_be | ent_be[slot];
                for (int b = 0; b < BE_W; b++) begin
                    if (ent_be[slot][b]) begin
                        fwd_data[b*8 +: 8] = ent_data[slot][b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/riscv_cache_writebuffer.sv
// Purpose: circular store write buffer with youngest-entry coalescing, draining into cache data memory.
// Latency: a push is visible on mem_* and to forwarding one cycle later at the earliest.
// Backpressure: drains only when mem_rdy_i=1; upstream must stall on full_o unless a pop or merge frees room.
module riscv_cache_writebuffer
    import riscv_cache_writebuffer_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SIZE       = 64,
    parameter int BLOCK_SIZE = XLEN,
    parameter int WAYS       = 2,
    parameter int DEPTH      = 2,
    localparam int IDX_BITS  = no_of_index_bits(SIZE, BLOCK_SIZE, WAYS),
    localparam int BE_W      = XLEN / 8
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                push_i,
    input  logic [IDX_BITS-1:0] push_idx_i,
    input  logic [WAYS-1:0]     push_way_i,
    input  logic [XLEN-1:0]     push_data_i,
    input  logic [BE_W-1:0]     push_be_i,
    output logic                full_o,
    output logic                empty_o,

    output logic                mem_we_o,
    input  logic                mem_rdy_i,
    output logic [IDX_BITS-1:0] mem_idx_o,
    output logic [WAYS-1:0]     mem_way_o,
    output logic [XLEN-1:0]     mem_data_o,
    output logic [BE_W-1:0]     mem_be_o,

    input  logic [IDX_BITS-1:0] lookup_idx_i,
    input  logic [WAYS-1:0]     lookup_way_i,
    output logic [BE_W-1:0]     fwd_be_o,
    output logic [XLEN-1:0]     fwd_data_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Same layout as wb_entry_t, but sized from this instance's parameters
    typedef struct packed {
        logic                valid;
        logic [IDX_BITS-1:0] idx;
        logic [WAYS-1:0]     way;
        logic [XLEN-1:0]     data;
        logic [BE_W-1:0]     be;
    } entry_t;

    entry_t           ent [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] youngest;
    logic [CNT_W-1:0] count;

    logic empty;
    logic full;
    logic pop;
    logic coalesce;
    logic alloc;

    // Byte-wise merge of a new store into an existing word
    function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0] old_d,
                                                    input logic [XLEN-1:0] new_d,
                                                    input logic [BE_W-1:0] be);
        logic [XLEN-1:0] res;
        res = old_d;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) res[b*8 +: 8] = new_d[b*8 +: 8];
        end
        return res;
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign youngest = tail - PTR_W'(1);
    assign pop      = !empty && mem_rdy_i;

    // Merge only into the youngest entry, and never into a head that leaves this cycle
    assign coalesce = push_i && !empty &&
                      (ent[youngest].idx == push_idx_i) &&
                      (ent[youngest].way == push_way_i) &&
                      !(pop && (count == CNT_W'(1)));

    // When full, an allocation reuses the slot the head is vacating
    assign alloc    = push_i && !coalesce && (!full || pop);

    assign empty_o    = empty;
    assign full_o     = full;
    assign mem_we_o   = !empty;
    assign mem_idx_o  = ent[head].idx;
    assign mem_way_o  = ent[head].way;
    assign mem_data_o = ent[head].data;
    assign mem_be_o   = ent[head].be;

    // FIFO state: pop clears the head, merge updates the youngest, allocate writes the tail
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i].valid <= 1'b0;
            end
        end else begin
            if (pop) begin
                ent[head].valid <= 1'b0;
                head            <= head + PTR_W'(1);
            end
            if (coalesce) begin
                ent[youngest].data <= merge_bytes(ent[youngest].data, push_data_i, push_be_i);
                ent[youngest].be   <= ent[youngest].be | push_be_i;
            end
            // Placed after the pop so a full-buffer allocate into the vacated slot wins
            if (alloc) begin
                ent[tail] <= '{valid: 1'b1, idx: push_idx_i, way: push_way_i,
                               data: push_data_i, be: push_be_i};
                tail      <= tail + PTR_W'(1);
            end
            count <= count + CNT_W'(alloc) - CNT_W'(pop);
        end
    end

    // A push into a full buffer with no pop and no merge would be silently lost
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push_i && full && !pop && !coalesce));
        end
    end

    logic [DEPTH-1:0]    f_valid;
    logic [IDX_BITS-1:0] f_idx  [DEPTH];
    logic [WAYS-1:0]     f_way  [DEPTH];
    logic [XLEN-1:0]     f_data [DEPTH];
    logic [BE_W-1:0]     f_be   [DEPTH];

    // Split the entry array into per-field views for the forwarding mux
    always_comb begin
        f_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            f_valid[i] = ent[i].valid;
            f_idx[i]   = ent[i].idx;
            f_way[i]   = ent[i].way;
            f_data[i]  = ent[i].data;
            f_be[i]    = ent[i].be;
        end
    end

    riscv_cache_wb_fwd #(
        .XLEN     (XLEN),
        .IDX_BITS (IDX_BITS),
        .WAYS     (WAYS),
        .DEPTH    (DEPTH)
    ) u_fwd (
        .head       (head),
        .ent_valid  (f_valid),
        .ent_idx    (f_idx),
        .ent_way    (f_way),
        .ent_data   (f_data),
        .ent_be     (f_be),
        .lookup_idx (lookup_idx_i),
        .lookup_way (lookup_way_i),
        .fwd_be     (fwd_be_o),
        .fwd_data   (fwd_data_o)
    );

endmodule

// File: tb/tb_riscv_cache_writebuffer.sv
// Purpose: directed plus random check of the write buffer against a queue-based model.
// Latency: model state advances at each clock edge; outputs compared mid-cycle.
// Backpressure: stimulus never pushes into a full buffer without a pop or merge.
module tb_riscv_cache_writebuffer;

    localparam int DEPTH = 4;
    // 64 KByte * 8192 bits / 32-bit blocks / 2 ways = 8192 sets -> 13 index bits
    localparam int IDXB  = 13;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        push_i;
    logic [IDXB-1:0] push_idx_i;
    logic [1:0]  push_way_i;
    logic [31:0] push_data_i;
    logic [3:0]  push_be_i;
    logic        full_o, empty_o, mem_we_o, mem_rdy_i;
    logic [IDXB-1:0] mem_idx_o;
    logic [1:0]  mem_way_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_be_o;
    logic [IDXB-1:0] lookup_idx_i;
    logic [1:0]  lookup_way_i;
    logic [3:0]  fwd_be_o;
    logic [31:0] fwd_data_o;

    always #5 clk = ~clk;

    riscv_cache_writebuffer #(
        .XLEN(32), .SIZE(64), .BLOCK_SIZE(32), .WAYS(2), .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .push_i(push_i), .push_idx_i(push_idx_i), .push_way_i(push_way_i),
        .push_data_i(push_data_i), .push_be_i(push_be_i),
        .full_o(full_o), .empty_o(empty_o),
        .mem_we_o(mem_we_o), .mem_rdy_i(mem_rdy_i), .mem_idx_o(mem_idx_o),
        .mem_way_o(mem_way_o), .mem_data_o(mem_data_o), .mem_be_o(mem_be_o),
        .lookup_idx_i(lookup_idx_i), .lookup_way_i(lookup_way_i),
        .fwd_be_o(fwd_be_o), .fwd_data_o(fwd_data_o)
    );

    typedef struct {
        logic [IDXB-1:0] idx;
        logic [1:0]      way;
        logic [31:0]     data;
        logic [3:0]      be;
    } ment_t;

    ment_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic model_coal(input logic p, input logic [IDXB-1:0] i,
                                        input logic [1:0] w, input logic pp);
        if (!p || q.size() == 0) return 1'b0;
        if (q[q.size()-1].idx != i || q[q.size()-1].way != w) return 1'b0;
        if (pp && q.size() == 1) return 1'b0;
        return 1'b1;
    endfunction

    // Compare every observable output against the queue model
    task automatic compare_model();
        logic [3:0]  e_be;
        logic [31:0] e_data, mask;
        chk("empty", empty_o, q.size() == 0);
        chk("full", full_o, q.size() == DEPTH);
        chk("mem_we", mem_we_o, q.size() != 0);
        if (q.size() != 0) begin
            chk("mem_idx", mem_idx_o, q[0].idx);
            chk("mem_way", mem_way_o, q[0].way);
            chk("mem_data", mem_data_o, q[0].data);
            chk("mem_be", mem_be_o, q[0].be);
        end
        e_be = '0;
        e_data = '0;
        foreach (q[k]) begin
            if (q[k].idx == lookup_idx_i && (q[k].way & lookup_way_i) != 2'b00) begin
                e_be = e_be | q[k].be;
                for (int b = 0; b < 4; b++)
                    if (q[k].be[b]) e_data[b*8 +: 8] = q[k].data[b*8 +: 8];
            end
        end
        mask = '0;
        for (int b = 0; b < 4; b++) if (e_be[b]) mask[b*8 +: 8] = 8'hFF;
        chk("fwd_be", fwd_be_o, e_be);
        chk("fwd_data", fwd_data_o & mask, e_data & mask);
    endtask

    task automatic drive(input logic r, input logic p, input logic [IDXB-1:0] idx,
                         input logic [1:0] way, input logic [31:0] data, input logic [3:0] be,
                         input logic rdy, input logic [IDXB-1:0] lidx, input logic [1:0] lway);
        @(negedge clk);
        rst_i = r; push_i = p; push_idx_i = idx; push_way_i = way;
        push_data_i = data; push_be_i = be; mem_rdy_i = rdy;
        lookup_idx_i = lidx; lookup_way_i = lway;
        #1;
        compare_model();
    endtask

    // Apply this cycle's push/pop/reset to the model, then take the clock edge
    task automatic advance();
        logic pp, cc;
        ment_t t;
        pp = (q.size() != 0) && mem_rdy_i;
        cc = model_coal(push_i, push_idx_i, push_way_i, pp);
        if (rst_i) begin
            q.delete();
        end else begin
            if (cc) begin
                t = q[q.size()-1];
                for (int b = 0; b < 4; b++)
                    if (push_be_i[b]) t.data[b*8 +: 8] = push_data_i[b*8 +: 8];
                t.be = t.be | push_be_i;
                q[q.size()-1] = t;
            end
            if (pp) void'(q.pop_front());
            if (push_i && !cc) begin
                t.idx = push_idx_i; t.way = push_way_i; t.data = push_data_i; t.be = push_be_i;
                q.push_back(t);
            end
        end
        @(posedge clk);
    endtask

    initial begin
        logic p, r, rdy, pp;
        logic [IDXB-1:0] idx, lidx;
        logic [1:0] way, lway;
        int exp_idx[3];

        rst_i = 1'b1; push_i = 1'b0; push_idx_i = '0; push_way_i = '0;
        push_data_i = '0; push_be_i = '0; mem_rdy_i = 1'b0;
        lookup_idx_i = '0; lookup_way_i = '0;
        repeat (2) @(posedge clk);

        // 1: reset state, then a single store drains in one cycle
        drive(0, 1, 13'd5, 2'b01, 32'hDEADBEEF, 4'hF, 1, 13'd5, 2'b01);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_fwd_be", fwd_be_o, 0);
        advance();
        drive(0, 0, 0, 0, 0, 0, 1, 13'd5, 2'b01);
        chk("t1_we", mem_we_o, 1);
        chk("t1_idx", mem_idx_o, 13'd5);
        chk("t1_way", mem_way_o, 2'b01);
        chk("t1_data", mem_data_o, 32'hDEADBEEF);
        chk("t1_be", mem_be_o, 4'hF);
        chk("t1_fwd_on_pop", fwd_be_o, 4'hF);
        advance();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("t1_empty", empty_o, 1);
        chk("t1_we_off", mem_we_o, 0);
        advance();

        // 2: fill to full, push with a simultaneous pop, drain in order
        for (int i = 1; i <= DEPTH; i++) begin
            drive(0, 1, IDXB'(i), 2'b01, 32'h100 + i, 4'hF, 0, 0, 0);
            advance();
        end
        drive(0, 1, 13'd5, 2'b01, 32'h105, 4'hF, 1, 0, 0);
        chk("t2_full", full_o, 1);
        chk("t2_head", mem_idx_o, 13'd1);
        advance();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("t2_still_full", full_o, 1);
        chk("t2_order2", mem_idx_o, 13'd2);
        advance();
        exp_idx = '{3, 4, 5};
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
            chk("t2_order", mem_idx_o, IDXB'(exp_idx[i]));
            advance();
        end

        // 3: two stores to the same word merge into one entry
        drive(0, 1, 13'd4, 2'b01, 32'h11223344, 4'b0011, 0, 0, 0);
        chk("t2_drained", empty_o, 1);
        advance();
        drive(0, 1, 13'd4, 2'b01, 32'hAABBCCDD, 4'b1100, 0, 0, 0);
        advance();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("t3_data", mem_data_o, 32'hAABB3344);
        chk("t3_be", mem_be_o, 4'hF);
        chk("t3_not_full", full_o, 0);
        advance();

        // 4/5: youngest-wins forwarding across non-adjacent entries
        drive(0, 1, 13'd7, 2'b01, 32'h01010101, 4'hF, 0, 0, 0);
        chk("t3_single", empty_o, 1);
        advance();
        drive(0, 1, 13'd8, 2'b01, 32'h08080808, 4'hF, 0, 0, 0);
        advance();
        drive(0, 1, 13'd7, 2'b01, 32'h000000FF, 4'b0001, 0, 0, 0);
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 13'd7, 2'b01);
        chk("t4_fwd_be", fwd_be_o, 4'hF);
        chk("t4_fwd_data", fwd_data_o, 32'h010101FF);
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 13'd7, 2'b10);
        chk("t5_fwd_be", fwd_be_o, 4'h0);
        advance();

        // 6: stalls hold mem_*, one pop per ready cycle, reset mid-drain
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("t6_hold_idx", mem_idx_o, 13'd7);
        chk("t6_hold_data", mem_data_o, 32'h01010101);
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t6_pop1", mem_idx_o, 13'd8);
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t6_stall", mem_idx_o, 13'd8);
        advance();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("t6_we_on_rst", mem_we_o, 1);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 13'd7, 2'b11);
            chk("t6_post_rst_empty", empty_o, 1);
            chk("t6_post_rst_we", mem_we_o, 0);
            advance();
        end

        // Random traffic over a small index range to exercise merging
        for (int n = 0; n < 3000; n++) begin
            r    = ($urandom_range(0, 249) == 0);
            p    = $urandom_range(0, 1);
            idx  = IDXB'($urandom_range(0, 2));
            way  = $urandom_range(0, 1) ? 2'b01 : 2'b10;
            rdy  = ($urandom_range(0, 2) != 0);
            lidx = IDXB'($urandom_range(0, 2));
            lway = 2'($urandom_range(1, 3));
            pp   = (q.size() != 0) && rdy;
            if (q.size() == DEPTH && !pp && !model_coal(p, idx, way, pp)) p = 1'b0;
            drive(r, p, idx, way, $urandom, 4'($urandom), rdy, lidx, lway);
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
